dmem_arbiter: RTL and testbench

- Two-requester arbiter sharing the single data-memory port (req/gnt/rvalid protocol) between the MEM-stage load/store unit (port 0) and a secondary master (port 1, e.g. debug/DMA).
- Sits between the LSU and the data-memory interface.
- Round-robin arbitration, request locking until grant, in-order response routing through an owner FIFO.

---
 rtl/dmem_arbiter.sv | 169 ++++++++++++++++
 tb/tb_dmem_arbiter.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - two-port round-robin arbiter for the shared data-memory req/gnt/rvalid port
// Optional: define DMEM_ARB_FIXED_PRIO_EN to replace round-robin with fixed port-0 priority.
module dmem_arbiter #(
    parameter int unsigned ADDR_WIDTH      = 32,
    parameter int unsigned DATA_WIDTH      = 32,
    parameter int unsigned MAX_OUTSTANDING = 2
) (
    input  logic                                 clk_i,
    input  logic                                 rst_ni,

    input  logic                                 m0_req_i,
    output logic                                 m0_gnt_o,
    output logic                                 m0_rvalid_o,
    input  logic [ADDR_WIDTH-1:0]                m0_addr_i,
    input  logic                                 m0_we_i,
    input  logic [DATA_WIDTH-1:0]                m0_wdata_i,
    output logic [DATA_WIDTH-1:0]                m0_rdata_o,

    input  logic                                 m1_req_i,
    output logic                                 m1_gnt_o,
    output logic                                 m1_rvalid_o,
    input  logic [ADDR_WIDTH-1:0]                m1_addr_i,
    input  logic                                 m1_we_i,
    input  logic [DATA_WIDTH-1:0]                m1_wdata_i,
    output logic [DATA_WIDTH-1:0]                m1_rdata_o,

    output logic                                 mem_req_o,
    input  logic                                 mem_gnt_i,
    input  logic                                 mem_rvalid_i,
    output logic [ADDR_WIDTH-1:0]                mem_addr_o,
    output logic                                 mem_we_o,
    output logic [DATA_WIDTH-1:0]                mem_wdata_o,
    input  logic [DATA_WIDTH-1:0]                mem_rdata_i,

    output logic [$clog2(MAX_OUTSTANDING+1)-1:0] outstanding_o,
    output logic                                 rsp_err_o
);

    localparam int unsigned CNT_W = $clog2(MAX_OUTSTANDING + 1);
    localparam int unsigned PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;

    logic                 lock_q;
    logic                 lock_port_q;
    logic                 lock_act;
    logic                 pref;
    logic                 sel;
    logic                 full;
    logic                 empty;
    logic                 handshake;
    logic                 pop;
    logic                 head;
    logic                 rsp_err_q;
    logic [CNT_W-1:0]     count_q;
    logic [PTR_W-1:0]     wr_ptr_q;
    logic [PTR_W-1:0]     rd_ptr_q;
    logic                 owner_q [MAX_OUTSTANDING];

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(MAX_OUTSTANDING - 1)) ? '0 : p + 1'b1;
    endfunction

`ifdef DMEM_ARB_FIXED_PRIO_EN
    assign pref = 1'b0;
`else
    logic pref_q;

    // Preference flips to the port that lost the last handshake.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pref_q <= 1'b0;
        end else if (handshake) begin
            pref_q <= ~sel;
        end
    end

    assign pref = pref_q;
`endif

    // A lock is only honoured while its owner keeps requesting.
    assign lock_act = lock_q & (lock_port_q ? m1_req_i : m0_req_i);

    always_comb begin
        sel = pref;
        if (lock_act) begin
            sel = lock_port_q;
        end else if (m0_req_i && !m1_req_i) begin
            sel = 1'b0;
        end else if (m1_req_i && !m0_req_i) begin
            sel = 1'b1;
        end
    end

    // Full is taken from the registered count, so a same-cycle pop cannot unblock.
    assign full      = (count_q == CNT_W'(MAX_OUTSTANDING));
    assign empty     = (count_q == '0);
    assign mem_req_o = (m0_req_i | m1_req_i) & ~full;
    assign handshake = mem_req_o & mem_gnt_i;

    always_comb begin
        mem_addr_o  = m0_addr_i;
        mem_we_o    = m0_we_i;
        mem_wdata_o = m0_wdata_i;
        if (sel) begin
            mem_addr_o  = m1_addr_i;
            mem_we_o    = m1_we_i;
            mem_wdata_o = m1_wdata_i;
        end
    end

    assign m0_gnt_o = handshake & ~sel;
    assign m1_gnt_o = handshake &  sel;

    assign pop         = mem_rvalid_i & ~empty;
    assign head        = owner_q[rd_ptr_q];
    assign m0_rvalid_o = pop & ~head;
    assign m1_rvalid_o = pop &  head;
    assign m0_rdata_o  = mem_rdata_i;
    assign m1_rdata_o  = mem_rdata_i;

    assign outstanding_o = count_q;
    assign rsp_err_o     = rsp_err_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            lock_q      <= 1'b0;
            lock_port_q <= 1'b0;
        end else if (handshake) begin
            lock_q <= 1'b0;
        end else if (mem_req_o) begin
            lock_q      <= 1'b1;
            lock_port_q <= sel;
        end else if (!lock_act) begin
            lock_q <= 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < MAX_OUTSTANDING; i++) begin
                owner_q[i] <= 1'b0;
            end
        end else begin
            if (handshake) begin
                owner_q[wr_ptr_q] <= sel;
                wr_ptr_q          <= ptr_inc(wr_ptr_q);
            end
            if (pop) begin
                rd_ptr_q <= ptr_inc(rd_ptr_q);
            end
            case ({handshake, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rsp_err_q <= 1'b0;
        end else begin
            rsp_err_q <= mem_rvalid_i & empty;
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - scoreboard bench for dmem_arbiter grant order, locking, FIFO routing and errors
module tb_dmem_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int MO = 2;
`ifdef DMEM_ARB_FIXED_PRIO_EN
    localparam bit FIXED = 1'b1;
`else
    localparam bit FIXED = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          m0_req = 1'b0, m0_gnt, m0_rvalid, m0_we = 1'b0;
    logic [AW-1:0] m0_addr = '0;
    logic [DW-1:0] m0_wdata = '0, m0_rdata;
    logic          m1_req = 1'b0, m1_gnt, m1_rvalid, m1_we = 1'b0;
    logic [AW-1:0] m1_addr = '0;
    logic [DW-1:0] m1_wdata = '0, m1_rdata;
    logic          mem_req, mem_gnt = 1'b0, mem_rvalid = 1'b0, mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata, mem_rdata = '0;
    logic [$clog2(MO+1)-1:0] outstanding;
    logic          rsp_err;

    dmem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_OUTSTANDING(MO)) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .m0_req_i(m0_req), .m0_gnt_o(m0_gnt), .m0_rvalid_o(m0_rvalid), .m0_addr_i(m0_addr),
        .m0_we_i(m0_we), .m0_wdata_i(m0_wdata), .m0_rdata_o(m0_rdata),
        .m1_req_i(m1_req), .m1_gnt_o(m1_gnt), .m1_rvalid_o(m1_rvalid), .m1_addr_i(m1_addr),
        .m1_we_i(m1_we), .m1_wdata_i(m1_wdata), .m1_rdata_o(m1_rdata),
        .mem_req_o(mem_req), .mem_gnt_i(mem_gnt), .mem_rvalid_i(mem_rvalid), .mem_addr_o(mem_addr),
        .mem_we_o(mem_we), .mem_wdata_o(mem_wdata), .mem_rdata_i(mem_rdata),
        .outstanding_o(outstanding), .rsp_err_o(rsp_err)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    bit sb_owner[$];
    bit err_pend = 1'b0;
    bit exp_pref = 1'b0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One cycle: verify registered state, drive inputs, verify the response path.
    task automatic step(input bit r0, input logic [AW-1:0] a0, input bit w0,
                        input bit r1, input logic [AW-1:0] a1,
                        input bit g, input bit rv, input logic [DW-1:0] rd);
        bit own;
        @(negedge clk);
        check("outstanding", 64'(outstanding), 64'(sb_owner.size()));
        check("rsp_err", 64'(rsp_err), 64'(err_pend));
        m0_req = r0; m0_addr = a0; m0_we = w0; m0_wdata = a0 ^ 32'h5a5a_0000;
        m1_req = r1; m1_addr = a1; m1_we = 1'b0; m1_wdata = a1 ^ 32'h0000_a5a5;
        mem_gnt = g; mem_rvalid = rv; mem_rdata = rd;
        #1;
        err_pend = 1'b0;
        if (rv && sb_owner.size() != 0) begin
            own = sb_owner.pop_front();
            check("m0_rvalid", 64'(m0_rvalid), 64'(!own));
            check("m1_rvalid", 64'(m1_rvalid), 64'(own));
            check(own ? "m1_rdata" : "m0_rdata", 64'(own ? m1_rdata : m0_rdata), 64'(rd));
        end else begin
            check("m0_rvalid_idle", 64'(m0_rvalid), 64'd0);
            check("m1_rvalid_idle", 64'(m1_rvalid), 64'd0);
            if (rv) err_pend = 1'b1;
        end
    endtask

    task automatic grant(input string tag, input int port);
        check({tag, "_m0_gnt"}, 64'(m0_gnt), 64'(port == 0));
        check({tag, "_m1_gnt"}, 64'(m1_gnt), 64'(port == 1));
        if (port >= 0) begin
            sb_owner.push_back(port[0]);
            if (!FIXED) exp_pref = (port == 0);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        m0_req = 1'b0; m1_req = 1'b0; mem_gnt = 1'b0; mem_rvalid = 1'b0;
        #1;
        check("rst_outstanding", 64'(outstanding), 64'd0);
        check("rst_rsp_err", 64'(rsp_err), 64'd0);
        check("rst_mem_req", 64'(mem_req), 64'd0);
        sb_owner.delete();
        err_pend = 1'b0;
        exp_pref = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        int p;
        do_reset();

        // Single port 0 read
        step(1, 32'h100, 0, 0, 0, 1, 0, 0);
        check("rd_addr", 64'(mem_addr), 64'h100);
        check("rd_req", 64'(mem_req), 64'd1);
        grant("rd", 0);
        step(0, 0, 0, 0, 0, 0, 1, 32'hDEADBEEF);
        step(0, 0, 0, 0, 0, 0, 0, 0);

        // Both ports requesting continuously
        for (int i = 0; i < 6; i++) begin
            p = exp_pref;
            step(1, 32'h200 + i, 0, 1, 32'h300 + i, 1, (i > 0), 32'(i));
            check("alt_addr", 64'(mem_addr), 64'(p ? 32'h300 + i : 32'h200 + i));
            grant("alt", p);
        end
        step(0, 0, 0, 0, 0, 0, 1, 32'd6);

        // Port 0 write, leaves port 1 preferred under round-robin
        step(1, 32'h3c, 1, 0, 0, 1, 0, 0);
        check("wr_we", 64'(mem_we), 64'd1);
        check("wr_wdata", 64'(mem_wdata), 64'(32'h3c ^ 32'h5a5a_0000));
        grant("wr", 0);
        step(0, 0, 0, 0, 0, 0, 1, 32'h55);

        // Lock holds port 0 while memory stalls
        step(1, 32'h40, 0, 0, 0, 0, 0, 0);
        check("lock0_addr", 64'(mem_addr), 64'h40);
        grant("lock0", -1);
        for (int i = 1; i < 3; i++) begin
            step(1, 32'h40, 0, 1, 32'h80, 0, 0, 0);
            check("lock_addr", 64'(mem_addr), 64'h40);
            check("lock_req", 64'(mem_req), 64'd1);
            grant("lock", -1);
        end
        step(1, 32'h40, 0, 1, 32'h80, 1, 0, 0);
        check("lock3_addr", 64'(mem_addr), 64'h40);
        grant("lock3", 0);
        step(0, 0, 0, 1, 32'h80, 1, 0, 0);
        check("lock4_addr", 64'(mem_addr), 64'h80);
        check("lock4_we", 64'(mem_we), 64'd0);
        grant("lock4", 1);
        step(0, 0, 0, 0, 0, 0, 1, 32'h11);
        step(0, 0, 0, 0, 0, 0, 1, 32'h22);

        // Full blocks requests; a same-cycle pop does not unblock
        step(1, 32'h500, 0, 0, 0, 1, 0, 0);
        grant("full0", 0);
        step(1, 32'h504, 0, 0, 0, 1, 0, 0);
        grant("full1", 0);
        step(1, 32'h508, 0, 0, 0, 1, 0, 0);
        check("full_req", 64'(mem_req), 64'd0);
        grant("full2", -1);
        step(1, 32'h508, 0, 0, 0, 1, 1, 32'hA);
        check("full_pop_req", 64'(mem_req), 64'd0);
        grant("full3", -1);
        step(1, 32'h508, 0, 0, 0, 1, 1, 32'hB);
        check("reissue_req", 64'(mem_req), 64'd1);
        check("reissue_addr", 64'(mem_addr), 64'h508);
        grant("reissue", 0);
        step(0, 0, 0, 0, 0, 0, 1, 32'hC);
        step(0, 0, 0, 0, 0, 0, 1, 32'hD);

        // Interleaved owners with a push coinciding with a pop
        step(1, 32'h600, 0, 0, 0, 1, 0, 0);
        grant("il0", 0);
        step(0, 0, 0, 1, 32'h604, 1, 0, 0);
        grant("il1", 1);
        step(0, 0, 0, 0, 0, 0, 1, 32'd1);
        step(1, 32'h608, 0, 0, 0, 1, 1, 32'd2);
        grant("il2", 0);
        step(0, 0, 0, 0, 0, 0, 1, 32'd3);
        step(0, 0, 0, 0, 0, 0, 0, 0);

        // Response with nothing outstanding
        step(0, 0, 0, 0, 0, 0, 1, 32'h77);
        step(0, 0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0);

        // Reset with a transaction in flight
        step(1, 32'h700, 0, 0, 0, 1, 0, 0);
        grant("pre_rst", 0);
        do_reset();
        step(0, 0, 0, 0, 0, 0, 1, 32'h99);
        step(0, 0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
